// File: rtl/y86_register_file_if.sv
// Y86-64 register file bus: two read ports (A, B) driven by decode and two
// write ports (E carries valE, M carries valM) driven by write-back.
// The master drives register IDs, enables and write data; the slave
// (the register file) returns read data.
interface y86_register_file_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  regWriteE;
  logic                  regWriteM;
  logic [3:0]            readRegA;
  logic [3:0]            readRegB;
  logic [3:0]            writeRegE;
  logic [3:0]            writeRegM;
  logic [DATA_WIDTH-1:0] writeDataE;
  logic [DATA_WIDTH-1:0] writeDataM;
  logic [DATA_WIDTH-1:0] readDataA;
  logic [DATA_WIDTH-1:0] readDataB;

  modport master (
    output regWriteE, regWriteM, readRegA, readRegB,
    output writeRegE, writeRegM, writeDataE, writeDataM,
    input  readDataA, readDataB
  );

  modport slave (
    input  regWriteE, regWriteM, readRegA, readRegB,
    input  writeRegE, writeRegM, writeDataE, writeDataM,
    output readDataA, readDataB
  );
endinterface

// File: rtl/y86_register_file.sv
// Y86-64 general-purpose register file: 15 x DATA_WIDTH registers, ID 4'hF is
// RNONE (reads as zero, writes are dropped). Two combinational read ports and
// two rising-edge write ports; when E and M target the same register on one
// edge, M wins so that popq %rsp leaves valM in %rsp.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward write data that
// is presented in the current cycle to the read ports (M before E, suppressed
// while reset is low). Without it, reads return stored contents only.
module y86_register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  y86_register_file_if.slave      rf
);

  localparam logic [3:0] RNONE = 4'hF;

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic                  write_e_s;
  logic                  write_m_s;
  logic [DATA_WIDTH-1:0] read_a_s;
  logic [DATA_WIDTH-1:0] read_b_s;

  // Stored value of a register; RNONE and any unmapped ID read as zero.
  function automatic logic [DATA_WIDTH-1:0] stored_value(input logic [3:0] id);
    logic [DATA_WIDTH-1:0] value;
    value = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (id == 4'(i)) begin
        value = regs_r[i];
      end else begin
        value = value;
      end
    end
    return value;
  endfunction

  // Qualified write strobes: enable high and destination is a real register.
  always_comb begin
    write_e_s = 1'b0;
    write_m_s = 1'b0;
    if (rf.regWriteE == 1'b1 && rf.writeRegE != RNONE) begin
      write_e_s = 1'b1;
    end else begin
      write_e_s = 1'b0;
    end
    if (rf.regWriteM == 1'b1 && rf.writeRegM != RNONE) begin
      write_m_s = 1'b1;
    end else begin
      write_m_s = 1'b0;
    end
  end

  // Register array: async clear, then E write followed by M write so M wins on a collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (write_m_s && rf.writeRegM == 4'(i)) begin
          regs_r[i] <= rf.writeDataM;
        end else if (write_e_s && rf.writeRegE == 4'(i)) begin
          regs_r[i] <= rf.writeDataE;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Read port A: stored value, optionally overridden by same-cycle write data.
  always_comb begin
    read_a_s = stored_value(rf.readRegA);
`ifdef REGFILE_WRITE_BYPASS_EN
    if (reset && write_m_s && rf.readRegA == rf.writeRegM) begin
      read_a_s = rf.writeDataM;
    end else if (reset && write_e_s && rf.readRegA == rf.writeRegE) begin
      read_a_s = rf.writeDataE;
    end else begin
      read_a_s = stored_value(rf.readRegA);
    end
`endif
  end

  // Read port B: same rules as port A, fully independent of it.
  always_comb begin
    read_b_s = stored_value(rf.readRegB);
`ifdef REGFILE_WRITE_BYPASS_EN
    if (reset && write_m_s && rf.readRegB == rf.writeRegM) begin
      read_b_s = rf.writeDataM;
    end else if (reset && write_e_s && rf.readRegB == rf.writeRegE) begin
      read_b_s = rf.writeDataE;
    end else begin
      read_b_s = stored_value(rf.readRegB);
    end
`endif
  end

  // Drive the read data onto the bus.
  always_comb begin
    rf.readDataA = read_a_s;
    rf.readDataB = read_b_s;
  end

endmodule

// File: tb/tb_y86_register_file.sv
// Self-checking bench for y86_register_file: directed steps followed by
// randomized traffic, all checked against an array-based reference model.
// Honours REGFILE_WRITE_BYPASS_EN when the build defines it.
`timescale 1ns/1ps
module tb_y86_register_file;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  logic [63:0] model [16];

  y86_register_file_if #(.DATA_WIDTH(64)) bus ();

  y86_register_file #(.DATA_WIDTH(64), .NUM_REGS(15)) dut (
    .clock (clock),
    .reset (reset),
    .rf    (bus)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  // Expected read value for an ID, given the model and the current inputs.
  function automatic logic [63:0] exp_read(input logic [3:0] id);
    logic [63:0] v;
    v = (id == 4'hF) ? 64'h0 : model[id];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (reset === 1'b1 && id != 4'hF) begin
      if (bus.regWriteM === 1'b1 && bus.writeRegM == id) v = bus.writeDataM;
      else if (bus.regWriteE === 1'b1 && bus.writeRegE == id) v = bus.writeDataE;
    end
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_A"}, bus.readDataA, exp_read(bus.readRegA));
    check({tag, "_B"}, bus.readDataB, exp_read(bus.readRegB));
  endtask

  // One rising edge; the model applies E then M (M wins) when out of reset.
  task automatic step();
    @(posedge clock);
    if (reset === 1'b1) begin
      if (bus.regWriteE === 1'b1 && bus.writeRegE != 4'hF) model[bus.writeRegE] = bus.writeDataE;
      if (bus.regWriteM === 1'b1 && bus.writeRegM != 4'hF) model[bus.writeRegM] = bus.writeDataM;
    end
    #1;
  endtask

  task automatic idle();
    bus.regWriteE = 1'b0;
    bus.regWriteM = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    reset          = 1'b0;
    bus.regWriteE  = 1'b0;
    bus.regWriteM  = 1'b0;
    bus.readRegA   = 4'h0;
    bus.readRegB   = 4'h5;
    bus.writeRegE  = 4'h0;
    bus.writeRegM  = 4'h0;
    bus.writeDataE = 64'h0;
    bus.writeDataM = 64'h0;

    // Reset held low, released between edges.
    #110;
    reset = 1'b1;
    #1;
    check("reset_a0", bus.readDataA, 64'h0);
    check("reset_b5", bus.readDataB, 64'h0);
    bus.readRegA = 4'hF; bus.readRegB = 4'hF;
    #1;
    check("reset_rnone_a", bus.readDataA, 64'h0);
    check("reset_rnone_b", bus.readDataB, 64'h0);

    // Single write on E.
    bus.regWriteE = 1'b1; bus.writeRegE = 4'h1; bus.writeDataE = 64'h8c0f000b;
    step();
    idle();
    bus.readRegA = 4'h1; bus.readRegB = 4'h1;
    #1;
    check("single_a", bus.readDataA, 64'h000000008c0f000b);
    check("single_b", bus.readDataB, 64'h000000008c0f000b);
    bus.readRegA = 4'h2;
    #1;
    check("single_reg2", bus.readDataA, 64'h0);

    // Dual write, different registers, then a collision on reg4.
    bus.regWriteE = 1'b1; bus.writeRegE = 4'h3; bus.writeDataE = 64'h1111;
    bus.regWriteM = 1'b1; bus.writeRegM = 4'h4; bus.writeDataM = 64'h2222;
    step();
    idle();
    bus.readRegA = 4'h3; bus.readRegB = 4'h4;
    #1;
    check("dual_reg3", bus.readDataA, 64'h1111);
    check("dual_reg4", bus.readDataB, 64'h2222);
    bus.regWriteE = 1'b1; bus.writeRegE = 4'h4; bus.writeDataE = 64'hAAAA;
    bus.regWriteM = 1'b1; bus.writeRegM = 4'h4; bus.writeDataM = 64'hBBBB;
    step();
    idle();
    #1;
    check("collide_m_wins", bus.readDataB, 64'hBBBB);

    // Write to RNONE is dropped; disabled enable keeps the old value.
    bus.regWriteE = 1'b1; bus.writeRegE = 4'hF; bus.writeDataE = 64'hFFFF;
    bus.regWriteM = 1'b1; bus.writeRegM = 4'hF; bus.writeDataM = 64'hFFFF;
    step();
    idle();
    for (int i = 0; i < 16; i++) begin
      bus.readRegA = 4'(i);
      #1;
      check($sformatf("rnone_reg%0d", i), bus.readDataA, exp_read(4'(i)));
    end
    bus.regWriteE = 1'b0; bus.writeRegE = 4'h1; bus.writeDataE = 64'hDEAD;
    step();
    bus.readRegA = 4'h1;
    #1;
    check("disabled_keep", bus.readDataA, 64'h000000008c0f000b);

    // Read-during-write on reg6: old value before the edge unless bypassed.
    bus.regWriteE = 1'b1; bus.writeRegE = 4'h6; bus.writeDataE = 64'h77;
    step();
    idle();
    bus.regWriteM = 1'b1; bus.writeRegM = 4'h6; bus.writeDataM = 64'h55;
    bus.readRegA = 4'h6;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_pre_edge", bus.readDataA, 64'h55);
`else
    check("rdw_pre_edge", bus.readDataA, 64'h77);
`endif
    step();
    idle();
    #1;
    check("rdw_post_edge", bus.readDataA, 64'h55);

    // Fill reg1..reg14 with nonzero values, then pull reset between edges.
    for (int i = 1; i < 15; i += 2) begin
      bus.regWriteE = 1'b1; bus.writeRegE = 4'(i);     bus.writeDataE = {32'hC0DE0000, 32'(i)};
      bus.regWriteM = 1'b1; bus.writeRegM = 4'(i + 1); bus.writeDataM = {32'hBEEF0000, 32'(i + 1)};
      step();
    end
    idle();
    bus.readRegA = 4'hE; bus.readRegB = 4'h1;
    #1;
    check("fill_reg14", bus.readDataA, 64'hBEEF00000000000E);
    check("fill_reg1", bus.readDataB, 64'hC0DE000000000001);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    for (int i = 0; i < 15; i++) begin
      bus.readRegA = 4'(i); bus.readRegB = 4'(14 - i);
      #1;
      check($sformatf("async_rst_a%0d", i), bus.readDataA, 64'h0);
      check($sformatf("async_rst_b%0d", 14 - i), bus.readDataB, 64'h0);
    end
    // Writes while reset is low have no effect, bypass included.
    bus.regWriteE = 1'b1; bus.writeRegE = 4'h3; bus.writeDataE = 64'h1234;
    bus.regWriteM = 1'b1; bus.writeRegM = 4'h7; bus.writeDataM = 64'h5678;
    bus.readRegA = 4'h3; bus.readRegB = 4'h7;
    #1;
    check("rst_bypass_a", bus.readDataA, 64'h0);
    check("rst_bypass_b", bus.readDataB, 64'h0);
    step();
    check("rst_write_a", bus.readDataA, 64'h0);
    check("rst_write_b", bus.readDataB, 64'h0);
    idle();
    #5;
    reset = 1'b1;
    #1;
    check_ports("rst_release");

    // Randomized traffic against the model, including RNONE and collisions.
    for (int n = 0; n < 400; n++) begin
      bus.regWriteE  = 1'($urandom_range(1, 0));
      bus.regWriteM  = 1'($urandom_range(1, 0));
      bus.writeRegE  = 4'($urandom_range(15, 0));
      bus.writeRegM  = ($urandom_range(3, 0) == 0) ? bus.writeRegE : 4'($urandom_range(15, 0));
      bus.writeDataE = {32'($urandom), 32'($urandom)};
      bus.writeDataM = {32'($urandom), 32'($urandom)};
      bus.readRegA   = 4'($urandom_range(15, 0));
      bus.readRegB   = ($urandom_range(3, 0) == 0) ? bus.writeRegM : 4'($urandom_range(15, 0));
      #1;
      check_ports($sformatf("rand_pre%0d", n));
      step();
      check_ports($sformatf("rand_post%0d", n));
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      bus.readRegA = 4'(i); bus.readRegB = 4'(15 - i);
      #1;
      check_ports($sformatf("final_scan%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
